// File: rtl/decode_pkg.sv
// Shared LEGv8 decode constants: opcode fields, immediate kinds and
// the zero-register helper used by the decode stage and register file.
package decode_pkg;

    localparam logic [4:0]  XZR_ADDR = 5'd31;

    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_D    = 3'd1,
        IMM_CB   = 3'd2,
        IMM_B    = 3'd3,
        IMM_I    = 3'd4
    } imm_kind_t;

    function automatic logic is_xzr(
        input logic [4:0] addr,
        input logic       zero_en
    );
        return zero_en && (addr == XZR_ADDR);
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// 32-entry register file: two combinational read ports with write-through
// bypass, one write port, optional hardwired zero register.
module regfile_bypass
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter bit ZERO_REG_EN = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [4:0]            rd_addr1,
    input  logic [4:0]            rd_addr2,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2,
    input  logic                  wr_en,
    input  logic [4:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    logic [DATA_WIDTH-1:0] regs_q [32];
    logic [DATA_WIDTH-1:0] regs_d [32];

    logic wr_ok;

    assign wr_ok = wr_en && !is_xzr(wr_addr, ZERO_REG_EN);

    always_comb begin
        regs_d = regs_q;
        if (wr_ok) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // A write in flight is visible to readers in the same cycle.
    assign rd_data1 = is_xzr(rd_addr1, ZERO_REG_EN) ? '0 :
                      (wr_en && wr_addr == rd_addr1) ? wr_data :
                      regs_q[rd_addr1];

    assign rd_data2 = is_xzr(rd_addr2, ZERO_REG_EN) ? '0 :
                      (wr_en && wr_addr == rd_addr2) ? wr_data :
                      regs_q[rd_addr2];

endmodule

// File: rtl/decode_stage.sv
// LEGv8 decode stage: register read, Reg2Loc, immediate extraction and
// a one-entry valid/ready output register with flush and stall refresh.
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter bit ZERO_REG_EN = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic                  flush,
    input  logic                  wb_en,
    input  logic [4:0]            wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [4:0]            out_rd,
    output logic [4:0]            out_rn,
    output logic [4:0]            out_rm,
    output logic [DATA_WIDTH-1:0] out_data1,
    output logic [DATA_WIDTH-1:0] out_data2,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic [2:0]            out_imm_kind
);

    logic [4:0]            rd_a;
    logic [4:0]            rn_a;
    logic [4:0]            rm_a;
    logic                  is_b;
    logic                  is_cb;
    logic                  is_ldst;
    logic                  is_stur;
    logic                  is_ai;
    logic [DATA_WIDTH-1:0] rf_data1;
    logic [DATA_WIDTH-1:0] rf_data2;
    logic [DATA_WIDTH-1:0] imm;
    imm_kind_t             kind;

    logic                  capture;
    logic                  hold;
    logic                  wb_ok;

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [4:0]            rd_q, rd_d;
    logic [4:0]            rn_q, rn_d;
    logic [4:0]            rm_q, rm_d;
    logic [DATA_WIDTH-1:0] data1_q, data1_d;
    logic [DATA_WIDTH-1:0] data2_q, data2_d;
    logic [DATA_WIDTH-1:0] imm_q, imm_d;
    imm_kind_t             kind_q, kind_d;

    assign rd_a    = in_instr[4:0];
    assign rn_a    = in_instr[9:5];
    assign is_b    = in_instr[31:26] == OP_B;
    assign is_cb   = (in_instr[31:24] == OP_CBZ) ||
                     (in_instr[31:24] == OP_CBNZ);
    assign is_stur = in_instr[31:21] == OP_STUR;
    assign is_ldst = is_stur || (in_instr[31:21] == OP_LDUR);
    assign is_ai   = (in_instr[31:22] == OP_ADDI) ||
                     (in_instr[31:22] == OP_SUBI);

    // Stores and compare-branches read their data register from Rt.
    assign rm_a = (is_stur || is_cb) ? rd_a : in_instr[20:16];

    always_comb begin
        imm  = '0;
        kind = IMM_NONE;
        unique case (1'b1)
            is_b: begin
                imm  = {{(DATA_WIDTH-26){in_instr[25]}}, in_instr[25:0]};
                kind = IMM_B;
            end
            is_cb: begin
                imm  = {{(DATA_WIDTH-19){in_instr[23]}}, in_instr[23:5]};
                kind = IMM_CB;
            end
            is_ldst: begin
                imm  = {{(DATA_WIDTH-9){in_instr[20]}}, in_instr[20:12]};
                kind = IMM_D;
            end
            is_ai: begin
                imm  = {{(DATA_WIDTH-12){1'b0}}, in_instr[21:10]};
                kind = IMM_I;
            end
            default: begin
            end
        endcase
    end

    regfile_bypass #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ZERO_REG_EN (ZERO_REG_EN)
    ) u_regfile (
        .clock    (clock),
        .reset_n  (reset_n),
        .rd_addr1 (rn_a),
        .rd_addr2 (rm_a),
        .rd_data1 (rf_data1),
        .rd_data2 (rf_data2),
        .wr_en    (wb_en),
        .wr_addr  (wb_addr),
        .wr_data  (wb_data)
    );

    assign in_ready = !valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;
    assign hold     = valid_q && !out_ready;
    assign wb_ok    = wb_en && !is_xzr(wb_addr, ZERO_REG_EN);

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        rd_d    = rd_q;
        rn_d    = rn_q;
        rm_d    = rm_q;
        data1_d = data1_q;
        data2_d = data2_q;
        imm_d   = imm_q;
        kind_d  = kind_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d = 1'b1;
            pc_d    = in_pc;
            rd_d    = rd_a;
            rn_d    = rn_a;
            rm_d    = rm_a;
            data1_d = rf_data1;
            data2_d = rf_data2;
            imm_d   = imm;
            kind_d  = kind;
        end else begin
            if (out_ready) begin
                valid_d = 1'b0;
            end
            // Keep stalled operands in step with late writebacks.
            if (hold && wb_ok) begin
                if (wb_addr == rn_q) data1_d = wb_data;
                if (wb_addr == rm_q) data2_d = wb_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rd_q    <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            data1_q <= '0;
            data2_q <= '0;
            imm_q   <= '0;
            kind_q  <= IMM_NONE;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            rn_q    <= rn_d;
            rm_q    <= rm_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            imm_q   <= imm_d;
            kind_q  <= kind_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_pc       = pc_q;
    assign out_rd       = rd_q;
    assign out_rn       = rn_q;
    assign out_rm       = rm_q;
    assign out_data1    = data1_q;
    assign out_data2    = data2_q;
    assign out_imm      = imm_q;
    assign out_imm_kind = kind_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: decode vector table with a register/handshake
// model and scoreboard, plus stall, flush and async-reset sequences.
module tb_decode_stage;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [63:0] imm;
        logic [2:0]  kind;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [63:0] wb_data;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [63:0] d1;
        logic [63:0] d2;
        logic [63:0] imm;
        logic [2:0]  kind;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [63:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [63:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_pc;
    logic [4:0]  out_rd;
    logic [4:0]  out_rn;
    logic [4:0]  out_rm;
    logic [63:0] out_data1;
    logic [63:0] out_data2;
    logic [63:0] out_imm;
    logic [2:0]  out_imm_kind;

    int errors = 0;
    int checks = 0;

    vec_t        tbl [11];
    vec_t        cur_v;
    exp_t        sb_q [$];
    logic [63:0] mreg [32];
    logic        mv = 1'b0;

    decode_stage #(
        .DATA_WIDTH  (64),
        .ZERO_REG_EN (1'b1)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .flush        (flush),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_rd       (out_rd),
        .out_rn       (out_rn),
        .out_rm       (out_rm),
        .out_data1    (out_data1),
        .out_data2    (out_data2),
        .out_imm      (out_imm),
        .out_imm_kind (out_imm_kind)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rd_model(input logic [4:0] a);
        if (a == 5'd31) return 64'h0;
        if (wb_en && wb_addr == a) return wb_data;
        return mreg[a];
    endfunction

    // Reference model of the handshake, register file and held bundle.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mv = 1'b0;
            sb_q.delete();
            for (int i = 0; i < 32; i++) mreg[i] = 64'h0;
        end else begin
            logic rdy;
            logic cap;
            exp_t e;
            rdy = !mv || out_ready;
            cap = in_valid && rdy && !flush;
            if (mv && !out_ready && !flush && wb_en && wb_addr != 5'd31 &&
                sb_q.size() > 0) begin
                if (sb_q[0].rn == wb_addr) sb_q[0].d1 = wb_data;
                if (sb_q[0].rm == wb_addr) sb_q[0].d2 = wb_data;
            end
            if (mv && (out_ready || flush) && sb_q.size() > 0)
                void'(sb_q.pop_front());
            if (cap) begin
                e.pc   = in_pc;
                e.rd   = cur_v.rd;
                e.rn   = cur_v.rn;
                e.rm   = cur_v.rm;
                e.d1   = rd_model(cur_v.rn);
                e.d2   = rd_model(cur_v.rm);
                e.imm  = cur_v.imm;
                e.kind = cur_v.kind;
                sb_q.push_back(e);
            end
            mv = flush ? 1'b0 : cap ? 1'b1 : out_ready ? 1'b0 : mv;
            if (wb_en && wb_addr != 5'd31) mreg[wb_addr] = wb_data;
        end
    end

    always @(negedge clock) begin
        chk("out_valid", 64'(out_valid), 64'(mv));
        chk("in_ready", 64'(in_ready), 64'(!mv || out_ready));
        if (mv && out_ready) begin
            chk("sb_depth", 64'(sb_q.size()), 64'd1);
            if (sb_q.size() > 0) begin
                chk("pc", out_pc, sb_q[0].pc);
                chk("rd", 64'(out_rd), 64'(sb_q[0].rd));
                chk("rn", 64'(out_rn), 64'(sb_q[0].rn));
                chk("rm", 64'(out_rm), 64'(sb_q[0].rm));
                chk("data1", out_data1, sb_q[0].d1);
                chk("data2", out_data2, sb_q[0].d2);
                chk("imm", out_imm, sb_q[0].imm);
                chk("kind", 64'(out_imm_kind), 64'(sb_q[0].kind));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input vec_t v, input logic [63:0] pc);
        cur_v    = v;
        in_instr = v.instr;
        in_pc    = pc;
        in_valid = 1'b1;
        wb_en    = v.wb_en;
        wb_addr  = v.wb_addr;
        wb_data  = v.wb_data;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        wb_en    = 1'b0;
    endtask

    initial begin
        vec_t stall_v;

        tbl[0]  = '{{11'b10001011000, 5'd1, 6'd0, 5'd1, 5'd2},
                    5'd2, 5'd1, 5'd1, 64'h0, 3'd0, 1'b0, 5'd0, 64'h0};
        tbl[1]  = '{{11'b11111000000, 9'h1F8, 2'b00, 5'd4, 5'd3},
                    5'd3, 5'd4, 5'd3, 64'hFFFF_FFFF_FFFF_FFF8, 3'd1,
                    1'b0, 5'd0, 64'h0};
        tbl[2]  = '{{11'b11111000010, 9'h07F, 2'b00, 5'd10, 5'd9},
                    5'd9, 5'd10, 5'd7, 64'h7F, 3'd1, 1'b0, 5'd0, 64'h0};
        tbl[3]  = '{{6'b000101, 26'h3FF_FFFF},
                    5'd31, 5'd31, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 3'd3,
                    1'b0, 5'd0, 64'h0};
        tbl[4]  = '{{6'b000101, 26'h000_0123},
                    5'd3, 5'd9, 5'd0, 64'h123, 3'd3, 1'b0, 5'd0, 64'h0};
        tbl[5]  = '{{8'b10110101, 19'h40000, 5'd12},
                    5'd12, 5'd0, 5'd12, 64'hFFFF_FFFF_FFFC_0000, 3'd2,
                    1'b0, 5'd0, 64'h0};
        tbl[6]  = '{{8'b10110100, 19'd5, 5'd5},
                    5'd5, 5'd5, 5'd5, 64'h5, 3'd2, 1'b1, 5'd5, 64'hAA};
        tbl[7]  = '{{10'b1001000100, 12'hFFF, 5'd14, 5'd13},
                    5'd13, 5'd14, 5'd31, 64'hFFF, 3'd4, 1'b1, 5'd31, 64'h55};
        tbl[8]  = '{{10'b1101000100, 12'h800, 5'd16, 5'd15},
                    5'd15, 5'd16, 5'd0, 64'h800, 3'd4, 1'b0, 5'd0, 64'h0};
        tbl[9]  = '{{11'b11111000011, 5'd5, 6'd0, 5'd6, 5'd7},
                    5'd7, 5'd6, 5'd5, 64'h0, 3'd0, 1'b1, 5'd6, 64'h66};
        tbl[10] = '{{11'b10001011000, 5'd31, 6'd0, 5'd31, 5'd0},
                    5'd0, 5'd31, 5'd31, 64'h0, 3'd0, 1'b0, 5'd0, 64'h0};

        stall_v = '{{11'b10001011000, 5'd8, 6'd0, 5'd7, 5'd6},
                    5'd6, 5'd7, 5'd8, 64'h0, 3'd0, 1'b0, 5'd0, 64'h0};
        cur_v = tbl[0];

        repeat (3) tick();
        chk("rst_pc", out_pc, 64'h0);
        chk("rst_rd", 64'(out_rd), 64'h0);
        chk("rst_rn", 64'(out_rn), 64'h0);
        chk("rst_rm", 64'(out_rm), 64'h0);
        chk("rst_data1", out_data1, 64'h0);
        chk("rst_data2", out_data2, 64'h0);
        chk("rst_imm", out_imm, 64'h0);
        chk("rst_kind", 64'(out_imm_kind), 64'h0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 32; i++) begin
            wb_en   = 1'b1;
            wb_addr = 5'(i);
            wb_data = (i == 1) ? 64'h10 :
                      (i == 31) ? 64'h55 : 64'hA000 + 64'(i);
            tick();
        end
        idle();
        tick();

        for (int k = 0; k < 11; k++) begin
            drive(tbl[k], 64'h4000 + 64'(4 * k));
            tick();
        end
        idle();
        repeat (2) tick();

        // Stall with a late writeback to the held Rn.
        out_ready = 1'b0;
        drive(stall_v, 64'h5000);
        tick();
        idle();
        wb_en   = 1'b1;
        wb_addr = 5'd7;
        wb_data = 64'h99;
        chk("stall_in_ready", 64'(in_ready), 64'h0);
        tick();
        wb_en = 1'b0;
        chk("refresh_data1", out_data1, 64'h99);
        chk("refresh_data2", out_data2, 64'hA008);
        drive(tbl[0], 64'h5004);
        wb_en = 1'b0;
        tick();
        idle();
        out_ready = 1'b1;
        tick();
        tick();
        chk("stall_consumed", 64'(out_valid), 64'h0);

        // Flush a held bundle while fetch offers another.
        out_ready = 1'b0;
        drive(tbl[1], 64'h6000);
        tick();
        flush = 1'b1;
        drive(tbl[2], 64'h6004);
        tick();
        flush = 1'b0;
        idle();
        chk("flush_held", 64'(out_valid), 64'h0);
        out_ready = 1'b1;
        flush = 1'b1;
        drive(tbl[3], 64'h6008);
        tick();
        flush = 1'b0;
        idle();
        chk("flush_capture", 64'(out_valid), 64'h0);
        tick();

        // Asynchronous reset in the middle of a stall.
        out_ready = 1'b0;
        drive(tbl[0], 64'h7000);
        tick();
        idle();
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_valid", 64'(out_valid), 64'h0);
        chk("areset_in_ready", 64'(in_ready), 64'h1);
        chk("areset_data1", out_data1, 64'h0);
        chk("areset_pc", out_pc, 64'h0);
        tick();
        reset_n = 1'b1;
        out_ready = 1'b1;
        drive(tbl[0], 64'h8000);
        tick();
        drive(tbl[2], 64'h8004);
        tick();
        idle();
        repeat (3) tick();

        chk("sb_drained", 64'(sb_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
